// File: rtl/windowed_regfile.sv
// SPARC-style windowed integer register file with post-reset zeroing sweep,
// write-first read bypass, doubleword access, and the PSR icc/ET/CWP, WIM and Y state.
module windowed_regfile #(
  parameter  int NWINDOWS = 8,
  parameter  int DATA_W   = 32,
  parameter  int REG_BITS = 5,
  localparam int CWP_W    = $clog2(NWINDOWS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_BITS-1:0]   rs1,
  input  logic [REG_BITS-1:0]   rs2,
  input  logic [REG_BITS-1:0]   rd,
  output logic [DATA_W-1:0]     val1,
  output logic [DATA_W-1:0]     val2,
  output logic [2*DATA_W-1:0]   val3,
  input  logic                  reg_write_en,
  input  logic                  reg_writeDouble_en,
  input  logic [REG_BITS-1:0]   wr_reg,
  input  logic [2*DATA_W-1:0]   data,
  input  logic                  save,
  input  logic                  restore,
  input  logic                  wim_we,
  input  logic [NWINDOWS-1:0]   wim_in,
  input  logic                  icc_en,
  input  logic [3:0]            icc_in,
  input  logic                  Y_en,
  input  logic [DATA_W-1:0]     Y_in,
  input  logic                  et_set,
  input  logic                  et_clr,
  output logic                  ready,
  output logic                  trap_ovf,
  output logic                  trap_unf,
  output logic [CWP_W-1:0]      cwp_out,
  output logic [3:0]            icc_out,
  output logic [NWINDOWS-1:0]   wim_out,
  output logic [DATA_W-1:0]     Y_out,
  output logic                  et_out
);

  localparam int NPHYS  = 8 + 16 * NWINDOWS;
  localparam int PHYS_W = $clog2(NPHYS);
  localparam int WIN_W  = CWP_W + 4;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Globals live at physical 0..7; windowed registers follow at 8..NPHYS-1.
  // The windowed offset wraps naturally because 16*NWINDOWS is a power of two.
  function automatic logic [PHYS_W-1:0] map_phys(input logic [REG_BITS-1:0] r,
                                                 input logic [CWP_W-1:0]    cwp);
    logic [WIN_W-1:0] off;
    off = WIN_W'(r) - WIN_W'(8) + {cwp, 4'b0000};
    if (r < REG_BITS'(8)) map_phys = PHYS_W'(r);
    else                  map_phys = PHYS_W'(8) + PHYS_W'(off);
  endfunction

  logic [DATA_W-1:0]   rf_mem [NPHYS];

  logic [0:0]          state_q, state_d;
  logic [PHYS_W-1:0]   cnt_q, cnt_d;
  logic [CWP_W-1:0]    cwp_q, cwp_d;
  logic [NWINDOWS-1:0] wim_q, wim_d;
  logic [3:0]          icc_q, icc_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic                et_q, et_d;
  logic                trap_ovf_q, trap_ovf_d;
  logic                trap_unf_q, trap_unf_d;

  logic                run;
  logic [REG_BITS-1:0] wa_idx, wb_idx;
  logic                wa_en, wb_en;
  logic [PHYS_W-1:0]   wa_phys, wb_phys;
  logic [DATA_W-1:0]   wa_data, wb_data;
  logic [CWP_W-1:0]    cwp_dec, cwp_inc;

  assign run = (state_q == ST_RUN);

  // Write decode: port A takes the single word or the even half, port B the odd half.
  always_comb begin
    wa_idx  = reg_writeDouble_en ? {wr_reg[REG_BITS-1:1], 1'b0} : wr_reg;
    wb_idx  = {wr_reg[REG_BITS-1:1], 1'b1};
    wa_en   = run && reg_write_en && (wa_idx != '0);
    wb_en   = run && reg_write_en && reg_writeDouble_en;
    wa_data = data[DATA_W-1:0];
    wb_data = data[2*DATA_W-1:DATA_W];
    wa_phys = map_phys(wa_idx, cwp_q);
    wb_phys = map_phys(wb_idx, cwp_q);
  end

  // Read ports: 0=rs1, 1=rs2, 2=even half of rd, 3=odd half of rd.
  logic [REG_BITS-1:0] rd_idx [4];
  logic [DATA_W-1:0]   rd_val [4];

  assign rd_idx[0] = rs1;
  assign rd_idx[1] = rs2;
  assign rd_idx[2] = {rd[REG_BITS-1:1], 1'b0};
  assign rd_idx[3] = {rd[REG_BITS-1:1], 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd
      logic [PHYS_W-1:0] rp;
      assign rp = map_phys(rd_idx[gi], cwp_q);
      // Reads return 0 during the sweep and for r0; otherwise write-first bypass.
      assign rd_val[gi] = (!run || rd_idx[gi] == '0)  ? '0      :
                          (wb_en && rp == wb_phys)     ? wb_data :
                          (wa_en && rp == wa_phys)     ? wa_data :
                          rf_mem[rp];
    end
  endgenerate

  assign val1 = rd_val[0];
  assign val2 = rd_val[1];
  assign val3 = {rd_val[3], rd_val[2]};

  // Next-state logic: zeroing sweep in INIT, window/trap/status updates in RUN.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cwp_d      = cwp_q;
    wim_d      = wim_q;
    icc_d      = icc_q;
    y_d        = y_q;
    et_d       = et_q;
    trap_ovf_d = 1'b0;
    trap_unf_d = 1'b0;
    cwp_dec    = cwp_q - 1'b1;
    cwp_inc    = cwp_q + 1'b1;
    if (!run) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == PHYS_W'(NPHYS - 1)) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end else begin
      // Trap checks look at the WIM value from before this edge.
      if (save && !restore) begin
        if (wim_q[cwp_dec]) trap_ovf_d = 1'b1;
        else                cwp_d      = cwp_dec;
      end
      if (restore && !save) begin
        if (wim_q[cwp_inc]) trap_unf_d = 1'b1;
        else                cwp_d      = cwp_inc;
      end
      if (wim_we) wim_d = wim_in;
      if (icc_en) icc_d = icc_in;
      if (Y_en)   y_d   = Y_in;
      if (et_set && !et_clr)      et_d = 1'b1;
      else if (et_clr && !et_set) et_d = 1'b0;
    end
  end

  // Control and status registers; reset drops back into the zeroing sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      cwp_q      <= '0;
      wim_q      <= '0;
      icc_q      <= '0;
      y_q        <= '0;
      et_q       <= 1'b0;
      trap_ovf_q <= 1'b0;
      trap_unf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cwp_q      <= cwp_d;
      wim_q      <= wim_d;
      icc_q      <= icc_d;
      y_q        <= y_d;
      et_q       <= et_d;
      trap_ovf_q <= trap_ovf_d;
      trap_unf_q <= trap_unf_d;
    end
  end

  // Register storage has no reset; the sweep clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!run) begin
      rf_mem[cnt_q] <= '0;
    end else begin
      if (wa_en) rf_mem[wa_phys] <= wa_data;
      if (wb_en) rf_mem[wb_phys] <= wb_data;
    end
  end

  assign ready    = run;
  assign trap_ovf = trap_ovf_q;
  assign trap_unf = trap_unf_q;
  assign cwp_out  = cwp_q;
  assign icc_out  = icc_q;
  assign wim_out  = wim_q;
  assign Y_out    = y_q;
  assign et_out   = et_q;

endmodule

// File: doc/windowed_regfile.md
Name: windowed_regfile

Overview:
- Parametrised SPARC integer unit register file: NWINDOWS overlapping windows of 16 registers plus 8 globals, with WIM-checked SAVE/RESTORE generating overflow/underflow traps.
- Adds a post-reset zeroing sequencer, same-cycle write-to-read bypass and doubleword access.
- Also holds the PSR fields icc, ET and CWP, plus WIM and Y.
- Sits between decode (read ports) and writeback (write port, icc/Y updates) in the integer pipeline.

Parameters:
- NWINDOWS, 8: number of register windows (power of 2, 2..32).
- DATA_W, 32: register width.
- REG_BITS, 5: architectural register index width.
- CWP_W, $clog2(NWINDOWS): CWP width (derived localparam).
- NPHYS, 8+16*NWINDOWS: physical register count (derived localparam).

Ports:
- clk  in  1  clock; all state updates on the rising edge only.
- reset  in  1  asynchronous, active-low reset.
- rs1, rs2, rd  in  REG_BITS  read register indices.
- val1, val2  out  DATA_W  read data (combinational).
- val3  out  2*DATA_W  doubleword read {r[rd|1], r[rd&~1]}.
- reg_write_en  in  1  write enable.
- reg_writeDouble_en  in  1  doubleword write qualifier.
- wr_reg  in  REG_BITS  write index.
- data  in  2*DATA_W  write data; low word to the even register, high word to the odd register.
- save, restore  in  1  window change requests.
- wim_we  in  1  WIM write enable.
- wim_in  in  NWINDOWS  new WIM value.
- icc_en  in  1  icc write enable.
- icc_in  in  4  new icc value.
- Y_en  in  1  Y write enable.
- Y_in  in  DATA_W  new Y value.
- et_set, et_clr  in  1  trap-enable control.
- ready  out  1  high once zeroing is complete.
- trap_ovf, trap_unf  out  1  registered one-cycle trap pulses.
- cwp_out  out  CWP_W  current CWP.
- icc_out  out  4  current icc.
- wim_out  out  NWINDOWS  current WIM.
- Y_out  out  DATA_W  current Y.
- et_out  out  1  current ET.

Behaviour:
- Address map:
  - r0..r7 map to globals.
  - r8..r31 map to physical ((r-8) + 16*CWP) mod (16*NWINDOWS).
  - Consequence: the ins of window w equal the outs of window w+1 (mod NWINDOWS).
- r0 always reads 0; writes to r0 are discarded.
- Reset (async, reset low):
  - CWP=0, WIM=0, icc=0, Y=0, ET=0.
  - trap_ovf=trap_unf=0, ready=0.
  - FSM enters INIT with sweep counter=0.
  - The storage array itself has no reset.
- FSM INIT:
  - Each cycle writes 0 to physical index = counter, then counter++.
  - After index NPHYS-1 is written, next state is RUN and ready=1.
  - Total time is exactly NPHYS cycles after reset deasserts.
  - During INIT: all requests (writes, save/restore, wim/icc/Y/et) are ignored and val1/val2/val3 read 0.
- FSM RUN: normal operation. Reset asserted mid-sweep or mid-RUN returns to INIT, counter=0.
- Write:
  - On the rising edge with reg_write_en, r[wr_reg] <= data[DATA_W-1:0], mapped with the pre-edge CWP.
  - With reg_writeDouble_en: the even register (wr_reg&~1) gets the low word and (wr_reg|1) gets the high word.
  - For wr_reg=0 doubleword, only r1 is written.
- Reads:
  - Combinational from current CWP.
  - Write-first bypass: if a read index matches an active write target in the same cycle (same mapping), the port returns the incoming data word.
- SAVE:
  - new = (CWP-1) mod NWINDOWS.
  - If WIM[new]: CWP unchanged and trap_ovf=1 next cycle.
  - Otherwise CWP <= new.
- RESTORE:
  - new = (CWP+1) mod NWINDOWS.
  - If WIM[new]: CWP unchanged and trap_unf=1 next cycle.
  - Otherwise CWP <= new.
- save and restore together: no-op, no trap.
- Trap pulses last exactly one cycle per request.
- Ordering and priority:
  - WIM write in the same cycle as save/restore: the trap check uses the old WIM.
  - icc_en loads icc_in; Y_en loads Y_in.
  - et_set sets ET, et_clr clears ET; both together leave ET unchanged.
- All status outputs are driven directly from their registers (no extra latency).

Test Plan:
- Reset, NWINDOWS=8 (NPHYS=136) -> ready low for 136 cycles, then high. CWP=0 and every val is 0. A write during INIT has no effect.
- Write r9=0xDEADBEEF at CWP=0, then SAVE (CWP=7) -> r25 reads 0xDEADBEEF. RESTORE returns CWP=0 and r9 still reads 0xDEADBEEF.
- WIM=0x80, CWP=0, SAVE -> trap_ovf one-cycle pulse, CWP stays 0. WIM=0x02, RESTORE -> trap_unf pulse, CWP stays 0.
- Doubleword write wr_reg=17, data=0x11111111_22222222 -> r16=0x22222222, r17=0x11111111. rd=16 reads val3=0x1111111122222222.
- Write r0=5 while reading rs1=0 -> val1=0. Write r3=0xA5 with rs2=3 in the same cycle -> val2=0xA5 (bypass).
- CWP=0, no WIM bits set: 8 RESTOREs wrap CWP back to 0. save+restore together -> CWP unchanged, no trap. Reset asserted mid-INIT (counter=50) -> sweep restarts from 0.
